// File: rtl/block_xfer_seq_pkg.sv
// Shared constants for the block-transfer sequencer: register-select indices,
// bc_dec bit positions, flag-vector layout and FSM state encoding.
package block_xfer_seq_pkg;

   localparam int REG_SELECT_WIDTH  = 11;
   localparam int REG_SELECT_IDX_HL = 10;
   localparam int REG_SELECT_IDX_DE = 9;

   localparam int BC_DEC_IDX_LD = 0;
   localparam int BC_DEC_IDX_CP = 1;

   localparam int FLAG_S  = 5;
   localparam int FLAG_Z  = 4;
   localparam int FLAG_H  = 3;
   localparam int FLAG_PV = 2;
   localparam int FLAG_N  = 1;
   localparam int FLAG_C  = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_WR     = 3'd2,
      ST_UPD_HL = 3'd3,
      ST_UPD_DE = 3'd4,
      ST_CHK    = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // Pointer step with natural 16-bit wrap in both directions.
   function automatic logic [15:0] step16(input logic [15:0] v, input logic dec);
      return dec ? (v - 16'd1) : (v + 16'd1);
   endfunction

endpackage

// File: rtl/block_xfer_seq_cmp8.sv
// 8-bit compare (a - b) producing sign, zero, half-borrow and match flags.
module block_xfer_seq_cmp8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       s,
   output logic       z,
   output logic       h,
   output logic       match
);

   logic [7:0] diff;

   assign diff  = a - b;
   assign s     = diff[7];
   assign z     = (diff == 8'h00);
   // Borrow out of the low nibble into bit 4.
   assign h     = (a[3:0] < b[3:0]);
   assign match = (a == b);

endmodule

// File: rtl/block_xfer_seq.sv
// Sequencer for Z80 LDI/LDD/LDIR/LDDR and CPI/CPD/CPIR/CPDR: runs the memory
// cycles and drives HL/DE writeback, BC decrement and CP flags to the regfile.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_RD     | read mem[src], hold until mem_ready
// ST_WR     | LD only: write data to mem[dst], hold until mem_ready
// ST_UPD_HL | write HL +-1, pulse bc_dec, CP flags strobe
// ST_UPD_DE | LD only: write DE +-1
// ST_CHK    | sample bc_zero / match, repeat or finish
// ST_DONE   | one-cycle done pulse
module block_xfer_seq
   import block_xfer_seq_pkg::*;
(
   input  logic                        clk,
   input  logic                        n_reset,
   input  logic                        start,
   input  logic                        op_cp,
   input  logic                        op_dec,
   input  logic                        op_rep,
   input  logic [15:0]                 hl_in,
   input  logic [15:0]                 de_in,
   input  logic [7:0]                  a_in,
   input  logic                        bc_zero,
   input  logic [5:0]                  flags_cur,
   output logic [15:0]                 mem_addr,
   output logic                        mem_rd,
   output logic                        mem_wr,
   output logic [7:0]                  mem_wdata,
   input  logic [7:0]                  mem_rdata,
   input  logic                        mem_ready,
   output logic [1:0]                  bc_dec,
   output logic                        reg_we,
   output logic [REG_SELECT_WIDTH-1:0] reg_write_addr,
   output logic [15:0]                 reg_in,
   output logic                        flags_we,
   output logic [5:0]                  flags_in,
   output logic                        busy,
   output logic                        done
);

   state_t      state, state_nxt;
   logic [15:0] src, dst;
   logic [7:0]  acc, data;
   logic        cp, dec, rep, match;

   logic        cmp_s, cmp_z, cmp_h, cmp_match;
   logic        flags_unused;

   assign flags_unused = ^flags_cur[5:1];

   block_xfer_seq_cmp8 u_cmp (
      .a     (acc),
      .b     (data),
      .s     (cmp_s),
      .z     (cmp_z),
      .h     (cmp_h),
      .match (cmp_match)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= ST_IDLE;
         src   <= 16'h0000;
         dst   <= 16'h0000;
         acc   <= 8'h00;
         data  <= 8'h00;
         cp    <= 1'b0;
         dec   <= 1'b0;
         rep   <= 1'b0;
         match <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && start) begin
            src   <= hl_in;
            dst   <= de_in;
            acc   <= a_in;
            cp    <= op_cp;
            dec   <= op_dec;
            rep   <= op_rep;
            match <= 1'b0;
         end
         if (state == ST_RD && mem_ready)
            data <= mem_rdata;
         if (state == ST_UPD_HL) begin
            src <= step16(src, dec);
            if (cp)
               match <= cmp_match;
         end
         if (state == ST_UPD_DE)
            dst <= step16(dst, dec);
      end
   end

   always_comb begin
      state_nxt      = state;
      mem_addr       = 16'h0000;
      mem_rd         = 1'b0;
      mem_wr         = 1'b0;
      mem_wdata      = 8'h00;
      bc_dec         = 2'b00;
      reg_we         = 1'b0;
      reg_write_addr = '0;
      reg_in         = 16'h0000;
      flags_we       = 1'b0;
      flags_in       = 6'b000000;
      done           = 1'b0;
      busy           = (state != ST_IDLE) && (state != ST_DONE);

      case (state)
         ST_IDLE: begin
            if (start)
               state_nxt = ST_RD;
         end
         ST_RD: begin
            mem_rd   = 1'b1;
            mem_addr = src;
            if (mem_ready)
               state_nxt = cp ? ST_UPD_HL : ST_WR;
         end
         ST_WR: begin
            mem_wr    = 1'b1;
            mem_addr  = dst;
            mem_wdata = data;
            if (mem_ready)
               state_nxt = ST_UPD_HL;
         end
         ST_UPD_HL: begin
            reg_we                            = 1'b1;
            reg_write_addr[REG_SELECT_IDX_HL] = 1'b1;
            reg_in                            = step16(src, dec);
            if (cp) begin
               bc_dec[BC_DEC_IDX_CP] = 1'b1;
               flags_we              = 1'b1;
               flags_in[FLAG_S]      = cmp_s;
               flags_in[FLAG_Z]      = cmp_z;
               flags_in[FLAG_H]      = cmp_h;
               flags_in[FLAG_PV]     = 1'b0;
               flags_in[FLAG_N]      = 1'b1;
               flags_in[FLAG_C]      = flags_cur[FLAG_C];
               state_nxt             = ST_CHK;
            end else begin
               bc_dec[BC_DEC_IDX_LD] = 1'b1;
               state_nxt             = ST_UPD_DE;
            end
         end
         ST_UPD_DE: begin
            reg_we                            = 1'b1;
            reg_write_addr[REG_SELECT_IDX_DE] = 1'b1;
            reg_in                            = step16(dst, dec);
            state_nxt                         = ST_CHK;
         end
         ST_CHK: begin
            // BC = 0 at entry wraps to 0xFFFF and keeps looping, as on the Z80.
            if (rep && !bc_zero && !(cp && match))
               state_nxt = ST_RD;
            else
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Directed bench for block_xfer_seq with a memory responder and a small
// regfile model (HL/DE/BC/flags observed from the writeback ports).
module tb_block_xfer_seq;
   import block_xfer_seq_pkg::*;

   logic                        clk = 1'b0;
   logic                        n_reset;
   logic                        start;
   logic                        op_cp, op_dec, op_rep;
   logic [15:0]                 hl_in, de_in;
   logic [7:0]                  a_in;
   logic                        bc_zero;
   logic [5:0]                  flags_cur;
   logic [15:0]                 mem_addr;
   logic                        mem_rd, mem_wr;
   logic [7:0]                  mem_wdata, mem_rdata;
   logic                        mem_ready = 1'b0;
   logic [1:0]                  bc_dec;
   logic                        reg_we;
   logic [REG_SELECT_WIDTH-1:0] reg_write_addr;
   logic [15:0]                 reg_in;
   logic                        flags_we;
   logic [5:0]                  flags_in;
   logic                        busy, done;

   always #5 clk = ~clk;

   block_xfer_seq dut (
      .clk(clk), .n_reset(n_reset), .start(start), .op_cp(op_cp), .op_dec(op_dec),
      .op_rep(op_rep), .hl_in(hl_in), .de_in(de_in), .a_in(a_in), .bc_zero(bc_zero),
      .flags_cur(flags_cur), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .bc_dec(bc_dec), .reg_we(reg_we), .reg_write_addr(reg_write_addr),
      .reg_in(reg_in), .flags_we(flags_we), .flags_in(flags_in), .busy(busy), .done(done)
   );

   logic [7:0]  rmem [0:65535];
   logic [7:0]  wmem [0:65535];
   assign mem_rdata = rmem[mem_addr];

   logic [15:0] bc_base = 16'd0;
   logic [15:0] dec_total = 16'd0;
   assign bc_zero = ((bc_base - dec_total) == 16'd0);

   int wait_n = 0;
   int wcnt = 0;
   always @(negedge clk) begin
      if (mem_rd || mem_wr) begin
         if (wcnt < wait_n) begin
            mem_ready <= 1'b0;
            wcnt      <= wcnt + 1;
         end else begin
            mem_ready <= 1'b1;
            wcnt      <= 0;
         end
      end else begin
         mem_ready <= 1'b0;
         wcnt      <= 0;
      end
   end

   logic [15:0] hl_last = 16'h0, de_last = 16'h0, rd_last = 16'h0;
   logic [5:0]  flags_last = 6'h0;
   int ld_pulses = 0, cp_pulses = 0, done_cnt = 0, wr_cnt = 0, hl_wr_cnt = 0, fl_cnt = 0;

   always @(posedge clk) begin
      if (n_reset) begin
         if (reg_we && reg_write_addr[REG_SELECT_IDX_HL]) begin
            hl_last   <= reg_in;
            hl_wr_cnt <= hl_wr_cnt + 1;
         end
         if (reg_we && reg_write_addr[REG_SELECT_IDX_DE])
            de_last <= reg_in;
         if (bc_dec[BC_DEC_IDX_LD]) ld_pulses <= ld_pulses + 1;
         if (bc_dec[BC_DEC_IDX_CP]) cp_pulses <= cp_pulses + 1;
         if (bc_dec != 2'b00) dec_total <= dec_total + 16'd1;
         if (mem_wr && mem_ready) begin
            wmem[mem_addr] <= mem_wdata;
            wr_cnt         <= wr_cnt + 1;
         end
         if (mem_rd && mem_ready) rd_last <= mem_addr;
         if (flags_we) begin
            flags_last <= flags_in;
            fl_cnt     <= fl_cnt + 1;
         end
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   int checks = 0;
   int errors = 0;
   logic stab_en = 1'b0;
   int rd_cycles = 0, wr_cycles = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_bc(input logic [15:0] v);
      bc_base = v + dec_total;
   endtask

   task automatic run_op(input logic cp, input logic dec, input logic rep,
                         input logic [15:0] hl, input logic [15:0] de,
                         input logic [7:0] a, input int poke, output int lat);
      logic got;
      got = 1'b0;
      lat = 0;
      @(negedge clk);
      op_cp = cp; op_dec = dec; op_rep = rep;
      hl_in = hl; de_in = de; a_in = a;
      start = 1'b1;
      for (int c = 1; c <= 400 && !got; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == poke) begin
            start = 1'b1; hl_in = 16'hDEAD; de_in = 16'hBEEF; op_rep = 1'b1;
         end else if (poke > 1 && c == poke + 1) begin
            start = 1'b0;
         end
         chk("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
         chk("reg_we_exclusive", {31'd0, reg_we & (mem_rd | mem_wr | done)}, 32'd0);
         if (stab_en) begin
            if (mem_rd) begin
               rd_cycles++;
               chk("rd_addr_stable", {16'd0, mem_addr}, 32'h4000);
            end
            if (mem_wr) begin
               wr_cycles++;
               chk("wr_addr_stable", {16'd0, mem_addr}, 32'h5000);
               chk("wr_data_stable", {24'd0, mem_wdata}, 32'hA5);
            end
         end
         if (done) begin
            lat = c;
            got = 1'b1;
         end
      end
      chk("done_seen", {31'd0, got}, 32'd1);
      @(negedge clk);
   endtask

   int lat, ld0, cp0, dn0, wr0, fl0, hlw0;
   logic seen_wr;

   initial begin
      n_reset = 1'b0; start = 1'b0; op_cp = 1'b0; op_dec = 1'b0; op_rep = 1'b0;
      hl_in = 16'h0; de_in = 16'h0; a_in = 8'h0; flags_cur = 6'h0;
      repeat (3) @(negedge clk);
      chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
      chk("rst_reg", {20'd0, reg_we, reg_write_addr}, 32'd0);
      chk("rst_flags_bc", {23'd0, flags_we, bc_dec, flags_in}, 32'd0);
      n_reset = 1'b1;

      // LDI
      rmem[16'h1000] = 8'h5A; set_bc(16'd3);
      ld0 = ld_pulses; dn0 = done_cnt;
      run_op(1'b0, 1'b0, 1'b0, 16'h1000, 16'h2000, 8'h00, 0, lat);
      chk("ldi_latency", lat, 6);
      chk("ldi_wdata", {24'd0, wmem[16'h2000]}, 32'h5A);
      chk("ldi_hl", {16'd0, hl_last}, 32'h1001);
      chk("ldi_de", {16'd0, de_last}, 32'h2001);
      chk("ldi_bc_pulses", ld_pulses - ld0, 1);
      chk("ldi_done_cnt", done_cnt - dn0, 1);
      chk("ldi_bc", {16'd0, bc_base - dec_total}, 32'd2);

      // LDDR across the 0x0000 boundary
      rmem[16'h0001] = 8'h11; rmem[16'h0000] = 8'h22; set_bc(16'd2);
      ld0 = ld_pulses; dn0 = done_cnt;
      run_op(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0101, 8'h00, 0, lat);
      chk("lddr_latency", lat, 11);
      chk("lddr_w1", {24'd0, wmem[16'h0101]}, 32'h11);
      chk("lddr_w2", {24'd0, wmem[16'h0100]}, 32'h22);
      chk("lddr_rd_last", {16'd0, rd_last}, 32'h0000);
      chk("lddr_hl", {16'd0, hl_last}, 32'hFFFF);
      chk("lddr_de", {16'd0, de_last}, 32'h00FF);
      chk("lddr_bc_pulses", ld_pulses - ld0, 2);
      chk("lddr_done_cnt", done_cnt - dn0, 1);

      // CPIR stops on match at the second byte
      flags_cur = 6'h01;
      rmem[16'h3000] = 8'h10; rmem[16'h3001] = 8'h42; rmem[16'h3002] = 8'h99;
      set_bc(16'd5);
      cp0 = cp_pulses; dn0 = done_cnt; wr0 = wr_cnt; fl0 = fl_cnt; ld0 = ld_pulses;
      run_op(1'b1, 1'b0, 1'b1, 16'h3000, 16'h0000, 8'h42, 0, lat);
      chk("cpir_latency", lat, 7);
      chk("cpir_flags", {26'd0, flags_last}, 32'h13);
      chk("cpir_cp_pulses", cp_pulses - cp0, 2);
      chk("cpir_ld_pulses", ld_pulses - ld0, 0);
      chk("cpir_flag_strobes", fl_cnt - fl0, 2);
      chk("cpir_hl", {16'd0, hl_last}, 32'h3002);
      chk("cpir_no_writes", wr_cnt - wr0, 0);
      chk("cpir_bc", {16'd0, bc_base - dec_total}, 32'd3);
      chk("cpir_done_cnt", done_cnt - dn0, 1);

      // CPD: negative result with half-borrow, carry preserved as 0
      flags_cur = 6'h00; rmem[16'h6000] = 8'h21; set_bc(16'd4);
      cp0 = cp_pulses;
      run_op(1'b1, 1'b1, 1'b0, 16'h6000, 16'h0000, 8'h10, 0, lat);
      chk("cpd_latency", lat, 4);
      chk("cpd_flags", {26'd0, flags_last}, 32'h2A);
      chk("cpd_hl", {16'd0, hl_last}, 32'h5FFF);
      chk("cpd_cp_pulses", cp_pulses - cp0, 1);

      // LDI with three wait cycles on both RD and WR
      wait_n = 3; stab_en = 1'b1; rd_cycles = 0; wr_cycles = 0;
      rmem[16'h4000] = 8'hA5; set_bc(16'd1);
      run_op(1'b0, 1'b0, 1'b0, 16'h4000, 16'h5000, 8'h00, 0, lat);
      stab_en = 1'b0; wait_n = 0;
      chk("wait_latency", lat, 12);
      chk("wait_rd_cycles", rd_cycles, 4);
      chk("wait_wr_cycles", wr_cycles, 4);
      chk("wait_wdata", {24'd0, wmem[16'h5000]}, 32'hA5);
      chk("wait_hl", {16'd0, hl_last}, 32'h4001);
      chk("wait_de", {16'd0, de_last}, 32'h5001);

      // start pulsed while busy is ignored
      rmem[16'h7000] = 8'h3C; set_bc(16'd2);
      dn0 = done_cnt;
      run_op(1'b0, 1'b0, 1'b0, 16'h7000, 16'h7100, 8'h00, 2, lat);
      chk("busy_start_latency", lat, 6);
      chk("busy_start_hl", {16'd0, hl_last}, 32'h7001);
      chk("busy_start_wdata", {24'd0, wmem[16'h7100]}, 32'h3C);
      repeat (4) @(negedge clk);
      chk("busy_start_idle", {31'd0, busy}, 32'd0);
      chk("busy_start_done_cnt", done_cnt - dn0, 1);

      // reset asserted while the write is waiting
      wait_n = 2; rmem[16'h8000] = 8'h77; set_bc(16'd1);
      hlw0 = hl_wr_cnt; wr0 = wr_cnt; seen_wr = 1'b0;
      op_cp = 1'b0; op_dec = 1'b0; op_rep = 1'b0;
      hl_in = 16'h8000; de_in = 16'h8100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 50 && !seen_wr; c++) begin
         @(negedge clk);
         if (mem_wr) seen_wr = 1'b1;
      end
      chk("abort_reached_wr", {31'd0, seen_wr}, 32'd1);
      #1 n_reset = 1'b0;
      #1;
      chk("abort_mem", {14'd0, mem_rd, mem_wr, mem_addr}, 32'd0);
      chk("abort_wdata", {24'd0, mem_wdata}, 32'd0);
      chk("abort_busy_regwe", {30'd0, busy, reg_we}, 32'd0);
      @(negedge clk);
      n_reset = 1'b1;
      wait_n = 0;
      repeat (2) @(negedge clk);
      chk("abort_no_hl_write", hl_wr_cnt - hlw0, 0);
      chk("abort_no_mem_write", wr_cnt - wr0, 0);
      chk("abort_still_idle", {31'd0, busy}, 32'd0);

      run_op(1'b0, 1'b0, 1'b0, 16'h8000, 16'h8100, 8'h00, 0, lat);
      chk("post_rst_latency", lat, 6);
      chk("post_rst_wdata", {24'd0, wmem[16'h8100]}, 32'h77);
      chk("post_rst_hl", {16'd0, hl_last}, 32'h8001);
      chk("post_rst_de", {16'd0, de_last}, 32'h8101);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
